// File: rtl/crc16_seq_arb.sv
// ============================================================================
// Module   : crc16_seq_arb
// Brief    : Round-robin shared bit-serial USB CRC16 (0x8005) engine.
//            Optional macro CRC16_USB_INV_EN: init 0xFFFF, inverted result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc16_seq_arb #(
  parameter int  NUM_REQ   = 2,
  parameter int  MAX_WORDS = 8,
  localparam int OWN_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [NUM_REQ-1:0]     req,
  output logic [NUM_REQ-1:0]     grant,
  input  logic [NUM_REQ*64-1:0]  req_data,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [15:0]            crc_out,
  output logic                   crc_valid,
  output logic [OWN_W-1:0]       crc_owner,
  output logic                   crc_err,
  output logic                   busy
);

  localparam int          CNT_W = $clog2(MAX_WORDS + 1);
  localparam logic [15:0] POLY  = 16'h8005;
`ifdef CRC16_USB_INV_EN
  localparam logic [15:0] LFSR_INIT = 16'hFFFF;
  localparam logic [15:0] OUT_XOR   = 16'hFFFF;
`else
  localparam logic [15:0] LFSR_INIT = 16'h0000;
  localparam logic [15:0] OUT_XOR   = 16'h0000;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [OWN_W-1:0]   rr_q, rr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [63:0]        sh_q, sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [5:0]         bitcnt_q, bitcnt_d;
  logic               last_q, last_d;
  logic [15:0]        crc_out_q, crc_out_d;
  logic               crc_valid_q, crc_valid_d;
  logic [OWN_W-1:0]   crc_owner_q, crc_owner_d;
  logic               crc_err_q, crc_err_d;

  logic [OWN_W-1:0]   pick_idx, pick_hi, pick_any, owner_inc;
  logic               has_hi, fb, cnt_full;

  // First requester at or after the RR pointer, else the lowest one (wrap).
  always_comb begin
    pick_hi  = '0;
    pick_any = '0;
    has_hi   = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) pick_any = OWN_W'(i);
      if (req[i] && (OWN_W'(i) >= rr_q)) begin
        pick_hi = OWN_W'(i);
        has_hi  = 1'b1;
      end
    end
    pick_idx = has_hi ? pick_hi : pick_any;
  end

  assign owner_inc = (owner_q == OWN_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign fb        = lfsr_q[15] ^ sh_q[63];
  assign cnt_full  = (cnt_q == CNT_W'(MAX_WORDS));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    lfsr_d      = lfsr_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    bitcnt_d    = bitcnt_q;
    last_d      = last_q;
    crc_out_d   = crc_out_q;
    crc_valid_d = 1'b0;
    crc_owner_d = crc_owner_q;
    crc_err_d   = crc_err_q;
    req_ready   = '0;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          owner_d  = pick_idx;
          grant_d  = NUM_REQ'(1) << pick_idx;
          lfsr_d   = LFSR_INIT;
          cnt_d    = '0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!req[owner_q]) begin
          grant_d = '0;
          rr_d    = owner_inc;
          state_d = S_IDLE;
        end else begin
          req_ready[owner_q] = req_valid[owner_q];
          if (req_valid[owner_q]) begin
            sh_d     = req_data[{owner_q, 6'd0} +: 64];
            last_d   = req_last[owner_q];
            cnt_d    = cnt_q + 1'b1;
            bitcnt_d = '0;
            state_d  = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        lfsr_d   = {lfsr_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
        sh_d     = {sh_q[62:0], 1'b0};
        bitcnt_d = bitcnt_q + 1'b1;
        if (bitcnt_q == 6'd63) begin
          if (last_q || cnt_full) begin
            // Result registers load here so they are valid during DONE.
            crc_valid_d = 1'b1;
            crc_out_d   = lfsr_d ^ OUT_XOR;
            crc_owner_d = owner_q;
            crc_err_d   = cnt_full && !last_q;
            state_d     = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: begin
        grant_d = '0;
        rr_d    = owner_inc;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_q        <= '0;
      grant_q     <= '0;
      lfsr_q      <= '0;
      sh_q        <= '0;
      cnt_q       <= '0;
      bitcnt_q    <= '0;
      last_q      <= 1'b0;
      crc_out_q   <= '0;
      crc_valid_q <= 1'b0;
      crc_owner_q <= '0;
      crc_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      lfsr_q      <= lfsr_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      bitcnt_q    <= bitcnt_d;
      last_q      <= last_d;
      crc_out_q   <= crc_out_d;
      crc_valid_q <= crc_valid_d;
      crc_owner_q <= crc_owner_d;
      crc_err_q   <= crc_err_d;
    end
  end

  assign grant     = grant_q;
  assign crc_out   = crc_out_q;
  assign crc_valid = crc_valid_q;
  assign crc_owner = crc_owner_q;
  assign crc_err   = crc_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_crc16_seq_arb.sv
// ============================================================================
// Module   : tb_crc16_seq_arb
// Brief    : Scoreboard bench for crc16_seq_arb with a polynomial-division model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crc16_seq_arb;
  localparam int NR = 2;
  localparam int MW = 8;
  localparam int OW = 1;

  logic              clk = 1'b0;
  logic              n_rst = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR-1:0]     grant;
  logic [NR*64-1:0]  req_data = '0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_last = '0;
  logic [NR-1:0]     req_ready;
  logic [15:0]       crc_out;
  logic              crc_valid;
  logic [OW-1:0]     crc_owner;
  logic              crc_err;
  logic              busy;

  crc16_seq_arb #(.NUM_REQ(NR), .MAX_WORDS(MW)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .grant(grant), .req_data(req_data),
    .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
    .crc_out(crc_out), .crc_valid(crc_valid), .crc_owner(crc_owner),
    .crc_err(crc_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct { int owner; logic [15:0] crc; logic err; } exp_t;
  exp_t exp_q[$];
  logic [63:0] words_m [NR][MW];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
  endtask

  // CRC as the remainder of (message * x^16) mod P by long division.
  function automatic logic [15:0] ref_crc(input int k, input int n);
    bit          m [MW*64+16];
    int          len;
    logic [16:0] p;
    logic [15:0] r;
    p   = 17'h18005;
    len = n * 64 + 16;
    for (int i = 0; i < MW*64+16; i++) m[i] = 1'b0;
    for (int w = 0; w < n; w++)
      for (int b = 0; b < 64; b++) m[w*64+b] = words_m[k][w][6'(63-b)];
`ifdef CRC16_USB_INV_EN
    for (int i = 0; i < 16; i++) m[i] = ~m[i];
`endif
    for (int i = 0; i < len - 16; i++)
      if (m[i])
        for (int j = 0; j <= 16; j++) m[i+j] = m[i+j] ^ p[5'(16-j)];
    for (int t = 0; t < 16; t++) r[4'(15-t)] = m[len-16+t];
`ifdef CRC16_USB_INV_EN
    r = ~r;
`endif
    return r;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_grant"},     grant,     0);
    chk({tag, "_ready"},     req_ready, 0);
    chk({tag, "_crc_out"},   crc_out,   0);
    chk({tag, "_crc_valid"}, crc_valid, 0);
    chk({tag, "_crc_owner"}, crc_owner, 0);
    chk({tag, "_crc_err"},   crc_err,   0);
    chk({tag, "_busy"},      busy,      0);
  endtask

  // Monitor: arbitration model, handshake timing and scoreboard pop.
  int          model_rr = 0;
  int          model_owner = 0;
  int          last_hs = -1000;
  logic [NR-1:0] prev_req = '0;
  logic [NR-1:0] prev_grant = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        model_rr = 0; prev_req = '0; prev_grant = '0; last_hs = -1000;
      end else begin
        if (grant != 0 && prev_grant == 0) begin
          int sel;
          sel = -1;
          for (int i = 0; i < NR; i++) begin
            int c;
            c = (model_rr + i) % NR;
            if (sel < 0 && prev_req[c]) sel = c;
          end
          if (sel < 0) sel = 0;
          chk("grant_rr", grant, 64'(1) << sel);
          model_owner = sel;
        end
        if (grant == 0 && prev_grant != 0) model_rr = (model_owner + 1) % NR;
        if (|req_ready) begin
          chk("ready_owner", req_ready, (64'(1) << model_owner) & 64'(req_valid));
          if (|(req_ready & req_valid)) begin
            chk("hs_spacing", 64'(cyc - last_hs >= 65), 1);
            last_hs = cyc;
          end
        end
        if (crc_valid) begin
          int idx;
          chk("crc_latency", cyc, last_hs + 65);
          chk("crc_owner", crc_owner, model_owner);
          idx = -1;
          for (int i = 0; i < exp_q.size(); i++)
            if (idx < 0 && exp_q[i].owner == int'(crc_owner)) idx = i;
          if (idx < 0) begin
            checks++; failures++;
            $display("FAIL unexpected_crc: got crc_valid owner %0d crc %0h, expected none", crc_owner, crc_out);
          end else begin
            chk("crc_value", crc_out, exp_q[idx].crc);
            chk("crc_err", crc_err, exp_q[idx].err);
            exp_q.delete(idx);
          end
        end
        prev_req = req;
        prev_grant = grant;
      end
    end
  end

  task automatic send_pkt(input int k, input int nw, input bit last_en, input int smin, input int smax);
    int   sent, t;
    bit   last_seen;
    exp_t e;
    sent      = (nw > MW) ? MW : nw;
    last_seen = last_en && (nw <= MW);
    e.owner = k;
    e.crc   = ref_crc(k, sent);
    e.err   = (sent == MW) && !last_seen;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req[k] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!grant[k] && t < 3000);
    if (!grant[k]) timeout_fail("wait_grant");
    for (int i = 0; i < sent; i++) begin
      @(posedge clk); #1;
      repeat ($urandom_range(smax, smin)) begin @(posedge clk); #1; end
      req_data[k*64 +: 64] = words_m[k][i];
      req_last[k]  = last_seen && (i == sent - 1);
      req_valid[k] = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!req_ready[k] && t < 3000);
      if (!req_ready[k]) timeout_fail("wait_ready");
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
      req_last[k]  = 1'b0;
    end
    t = 0;
    do begin @(negedge clk); t++; end
    while (!(crc_valid && crc_owner == OW'(k)) && t < 3000);
    if (!(crc_valid && crc_owner == OW'(k))) timeout_fail("wait_crc");
    @(posedge clk); #1;
    req[k] = 1'b0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    exp_q.delete();
    req = '0; req_valid = '0; req_last = '0;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  task automatic run_req(input int k);
    int nw;
    bit le;
    repeat (6) begin
      nw = $urandom_range(1, MW);
      le = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        nw = MW;
        le = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < MW; i++) begin
        case ($urandom_range(0, 5))
          0:       words_m[k][i] = 64'h0;
          1:       words_m[k][i] = '1;
          default: words_m[k][i] = {$urandom, $urandom};
        endcase
      end
      send_pkt(k, nw, le, 0, 3);
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end
  endtask

  initial begin
    int t;
    #1 n_rst = 1'b0;
    #1 check_reset_vals("rst");
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    check_reset_vals("idle");

    words_m[0][0] = 64'h1; send_pkt(0, 1, 1'b1, 0, 0);
    words_m[1][0] = 64'h2; send_pkt(1, 1, 1'b1, 0, 0);
    words_m[1][0] = 64'h0; send_pkt(1, 1, 1'b1, 0, 0);
    words_m[0][0] = 64'h0; words_m[0][1] = 64'h1;
    send_pkt(0, 2, 1'b1, 10, 10);

    do_reset();
    words_m[0][0] = 64'h1; words_m[1][0] = 64'h1;
    fork
      send_pkt(0, 1, 1'b1, 0, 0);
      send_pkt(1, 1, 1'b1, 0, 0);
    join

    for (int i = 0; i < MW; i++) words_m[0][i] = 64'h0;
    send_pkt(0, MW, 1'b0, 0, 2);

    // Abort: drop req while the owner sits in LOAD.
    @(posedge clk); #1 req[0] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!grant[0] && t < 100);
    if (!grant[0]) timeout_fail("abort_grant_wait");
    @(posedge clk); #1 req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_grant", grant, 0);
    chk("abort_busy", busy, 0);
    repeat (80) @(posedge clk);

    // Asynchronous reset in the middle of SHIFT.
    @(posedge clk); #1;
    req[0] = 1'b1; req_data[63:0] = 64'h1234_5678_9abc_def0; req_last[0] = 1'b1; req_valid[0] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready[0] && t < 100);
    if (!req_ready[0]) timeout_fail("rst_hs_wait");
    @(posedge clk); #1 req_valid[0] = 1'b0;
    repeat (20) @(posedge clk);
    #3 n_rst = 1'b0;
    #1 check_reset_vals("midrst");
    req = '0; req_last = '0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    words_m[0][0] = 64'h1; send_pkt(0, 1, 1'b1, 0, 0);

    fork
      run_req(0);
      run_req(1);
    join

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
